// File: rtl/fsab_rr_arbiter.sv
// rtl/fsab_rr_arbiter.sv - credit-metered round-robin FSAB request arbiter with burst hold
// Optional requester-0 priority build: define FSAB_ARB_PRIO_EN.
module fsab_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int DID_W   = 4,
    parameter int ADDR_W  = 31,
    parameter int LEN_W   = 3,
    parameter int DATA_W  = 64,
    parameter int MASK_W  = 8,
    parameter int CREDITS = 4,
    parameter int CRED_W  = 3
) (
    input  logic                   clk,
    input  logic                   Nrst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_mode,
    input  logic [NREQ*DID_W-1:0]  req_did,
    input  logic [NREQ*DID_W-1:0]  req_subdid,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*LEN_W-1:0]  req_len,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic [NREQ*MASK_W-1:0] req_mask,
    output logic                   fsabo_valid,
    output logic                   fsabo_mode,
    output logic [DID_W-1:0]       fsabo_did,
    output logic [DID_W-1:0]       fsabo_subdid,
    output logic [ADDR_W-1:0]      fsabo_addr,
    output logic [LEN_W-1:0]       fsabo_len,
    output logic [DATA_W-1:0]      fsabo_data,
    output logic [MASK_W-1:0]      fsabo_mask,
    input  logic                   fsabo_credit,
    output logic [3:0]             grant_id,
    output logic                   busy
);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CRED_W-1:0]   r_credits;
    logic [CRED_W:0]     w_cred_sum;
    logic [CRED_W-1:0]   w_cred_nxt;
    logic [3:0]          r_rr_ptr;
    logic [3:0]          r_grant;
    logic [LEN_W-1:0]    r_remaining;

    logic [2*NREQ-1:0]   w_rot;
    logic                w_found;
    logic [4:0]          w_sum;
    logic [3:0]          w_win;
    logic                w_win_mode;
    logic [LEN_W-1:0]    w_win_len;
    logic                w_burst_valid;
`ifdef FSAB_ARB_PRIO_EN
    logic                w_prio_win;
`endif

    logic                w_accept;
    logic                w_new_grant;
    logic [3:0]          w_sel;

    logic                w_mode;
    logic [DID_W-1:0]    w_did;
    logic [DID_W-1:0]    w_subdid;
    logic [ADDR_W-1:0]   w_addr;
    logic [LEN_W-1:0]    w_len;
    logic [DATA_W-1:0]   w_data;
    logic [MASK_W-1:0]   w_mask;

    // Rotate so index 0 is the rr pointer; first set bit is the winner.
    always_comb begin
        w_rot   = {req_valid, req_valid} >> r_rr_ptr;
        w_found = 1'b0;
        w_sum   = '0;
        w_win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rr_ptr} + 5'(i);
                if (w_sum >= 5'(NREQ)) begin
                    w_sum = w_sum - 5'(NREQ);
                end
                w_win = w_sum[3:0];
            end
        end
`ifdef FSAB_ARB_PRIO_EN
        w_prio_win = 1'b0;
        if (req_valid[0]) begin
            w_found    = 1'b1;
            w_win      = '0;
            w_prio_win = 1'b1;
        end
`endif
        w_win_mode    = 1'b0;
        w_win_len     = '0;
        w_burst_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == 4'(i)) begin
                w_win_mode = req_mode[i];
                w_win_len  = req_len[i*LEN_W +: LEN_W];
            end
            if (r_grant == 4'(i) && req_valid[i]) begin
                w_burst_valid = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_new_grant = 1'b0;
        w_sel       = r_grant;
        case (r_state)
            S_IDLE: begin
                w_sel = w_win;
                if (Nrst && r_credits != '0 && w_found) begin
                    w_accept    = 1'b1;
                    w_new_grant = 1'b1;
                    if (w_win_mode && w_win_len > LEN_W'(1)) begin
                        w_state_nxt = S_BURST;
                    end
                end
            end
            S_BURST: begin
                if (Nrst && w_burst_valid) begin
                    w_accept = 1'b1;
                    if (r_remaining == LEN_W'(1)) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        w_mode    = 1'b0;
        w_did     = '0;
        w_subdid  = '0;
        w_addr    = '0;
        w_len     = '0;
        w_data    = '0;
        w_mask    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel == 4'(i)) begin
                req_ready[i] = w_accept;
                w_mode       = req_mode[i];
                w_did        = req_did[i*DID_W +: DID_W];
                w_subdid     = req_subdid[i*DID_W +: DID_W];
                w_addr       = req_addr[i*ADDR_W +: ADDR_W];
                w_len        = req_len[i*LEN_W +: LEN_W];
                w_data       = req_data[i*DATA_W +: DATA_W];
                w_mask       = req_mask[i*MASK_W +: MASK_W];
            end
        end
    end

    // A returned credit is not visible to the grant decision until next cycle.
    always_comb begin
        w_cred_sum = {1'b0, r_credits} + {{CRED_W{1'b0}}, fsabo_credit}
                   - {{CRED_W{1'b0}}, w_new_grant};
        w_cred_nxt = w_cred_sum[CRED_W-1:0];
        if (w_cred_sum > (CRED_W+1)'(CREDITS)) begin
            w_cred_nxt = CRED_W'(CREDITS);
        end
    end

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            r_state     <= S_IDLE;
            r_credits   <= CRED_W'(CREDITS);
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_remaining <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_credits <= w_cred_nxt;
            if (w_new_grant) begin
                r_grant <= w_win;
`ifdef FSAB_ARB_PRIO_EN
                if (!w_prio_win) begin
                    r_rr_ptr <= (w_win == 4'(NREQ-1)) ? 4'd0 : w_win + 4'd1;
                end
`else
                r_rr_ptr <= (w_win == 4'(NREQ-1)) ? 4'd0 : w_win + 4'd1;
`endif
                if (w_win_mode && w_win_len > LEN_W'(1)) begin
                    r_remaining <= w_win_len - LEN_W'(1);
                end
            end else if (w_accept) begin
                r_remaining <= r_remaining - LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            fsabo_valid  <= 1'b0;
            fsabo_mode   <= 1'b0;
            fsabo_did    <= '0;
            fsabo_subdid <= '0;
            fsabo_addr   <= '0;
            fsabo_len    <= '0;
            fsabo_data   <= '0;
            fsabo_mask   <= '0;
        end else begin
            fsabo_valid <= w_accept;
            if (w_accept) begin
                fsabo_mode   <= w_mode;
                fsabo_did    <= w_did;
                fsabo_subdid <= w_subdid;
                fsabo_addr   <= w_addr;
                fsabo_len    <= w_len;
                fsabo_data   <= w_data;
                fsabo_mask   <= w_mask;
            end
        end
    end

    assign grant_id = r_grant;
    assign busy     = (r_state == S_BURST);

endmodule

// File: doc/fsab_rr_arbiter.md
Name: fsab_rr_arbiter

Overview:
- Round-robin arbiter that shares the single FSAB output port between NREQ requesters (caches, DMA engines, framebuffer fetch).
- Grants one requester per request and holds the grant for the full multi-beat write burst.
- Meters new requests against the slave's credit budget, issuing only while credits remain.
- Sits between the requesters and the memory-side FSAB request FIFO.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DID_W, 4, device/subdevice ID width.
- ADDR_W, 31, address width.
- LEN_W, 3, burst length field width.
- DATA_W, 64, data width.
- MASK_W, 8, byte mask width.
- CREDITS, 4, initial credit count; this is the slave FIFO depth.
- CRED_W, 3, credit counter width; must hold CREDITS.

Ports:
- clk  in  1  clock.
- Nrst  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester beat valid.
- req_ready  out  NREQ  beat accepted this cycle; one-hot or zero.
- req_mode  in  NREQ  1=write, 0=read; one bit per requester.
- req_did  in  NREQ*DID_W  requester DIDs, packed, requester 0 in the LSBs.
- req_subdid  in  NREQ*DID_W  requester subdevice IDs, packed.
- req_addr  in  NREQ*ADDR_W  requester addresses, packed.
- req_len  in  NREQ*LEN_W  requester burst lengths, packed.
- req_data  in  NREQ*DATA_W  requester write data, packed.
- req_mask  in  NREQ*MASK_W  requester byte masks, packed.
- fsabo_valid  out  1  output beat valid.
- fsabo_mode  out  1  output request mode.
- fsabo_did  out  DID_W  output DID.
- fsabo_subdid  out  DID_W  output subdevice ID.
- fsabo_addr  out  ADDR_W  output address.
- fsabo_len  out  LEN_W  output burst length.
- fsabo_data  out  DATA_W  output write data.
- fsabo_mask  out  MASK_W  output byte mask.
- fsabo_credit  in  1  one-cycle pulse; returns one credit.
- grant_id  out  4  index of the current or last granted requester.
- busy  out  1  burst in progress.

Behaviour:
- Reset: all fsabo_* outputs 0, req_ready 0, credits = CREDITS, rr pointer 0, state IDLE, grant_id 0, busy 0. Reset is honoured at any time, including mid-burst: the burst is abandoned and no further beats are emitted.
- Requester contract: holds valid and all fields stable until req_ready. A write presents len beats in consecutive or gapped cycles. Header fields stay constant across a burst.
- IDLE:
  - If credits != 0 and any req_valid is set, pick the first requester at or after the rr pointer (wrapping NREQ-1 to 0).
  - Assert its req_ready the same cycle (combinational from registered state). Consume one credit. Set rr pointer = winner+1 mod NREQ.
  - Write with len > 1: go to BURST with remaining = len-1.
  - Read, or write with len <= 1: stay in IDLE.
  - len = 0 is treated as 1.
- BURST: only the granted requester is eligible. Each cycle its req_valid is set, assert req_ready and decrement remaining. Remaining 1 -> 0 returns to IDLE. No credit is consumed and other requesters are ignored. Gaps are allowed; busy = 1 for the whole burst.
- Output register: each accepted beat appears on fsabo_* exactly 1 cycle later with fsabo_valid = 1. Cycles with no accepted beat drive fsabo_valid = 0; other fields hold their last values.
- Credits:
  - Credit pulse and consume in the same cycle: count unchanged.
  - Credit pulse at count = CREDITS: saturate.
  - At count = 0: no new grant, even if fsabo_credit pulses that cycle; there is no bypass.
- Issue rate: back-to-back grants are allowed, so a new header can follow the last burst beat the next cycle.
- Non-granted requesters never see req_ready while busy.

Optional Feature:
- FSAB_ARB_PRIO_EN defined:
  - Requester 0 is high priority. In IDLE it wins whenever it is valid, regardless of the rr pointer.
  - Its win does not update the rr pointer; the others remain round-robin among themselves.
  - It cannot preempt a BURST.
- Undefined: pure round-robin, as described above.

Test Plan:
- All 4 requesters issue reads continuously, credits returned 2 cycles after each issue -> grants 0,1,2,3,0,...; fsabo_valid each cycle with credits; data 1 cycle after req_ready.
- Req1 writes len=4 while req2 reads -> 4 consecutive req1 beats on fsabo, then req2; only 1 credit consumed.
- No credit returns, 6 reads pending -> exactly 4 issue, then stall. A single fsabo_credit pulse -> exactly one more issue the following cycle.
- Credit pulse in the same cycle as a grant at count 2 -> count stays 2; credit pulse at count 4 -> stays 4.
- Nrst low mid-burst (beat 2 of 4) -> outputs 0, credits 4, IDLE. After release a new request is granted normally.
- FSAB_ARB_PRIO_EN: req0 and req3 valid continuously -> req0 always wins in IDLE; a req3 burst in progress completes before req0 is granted.
